data_cache: RTL and testbench

- 2 KB, 2-way set-associative, write-through / no-write-allocate L1 data cache for the pipelined 16-bit CPU's MEM stage.
- Reads are combinational: hit data and the miss flag are driven in the same cycle.
- On a miss, an external memory controller fills the block word by word using load_data. It then commits the tag with load_tag on the final word.
- Writes to memory are handled externally; the cache only updates its own copy on a write hit.

---
 rtl/data_cache.sv | 132 +++++++++++++
 tb/tb_data_cache.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// rtl/data_cache.sv - 2 KB 2-way set-associative write-through L1 data cache
//
// Purpose: combinational-lookup data cache for the CPU MEM stage. Misses are
// filled word by word by an external memory controller (load_data), and the
// block is committed with load_tag. Write hits update the cached copy only;
// write misses do not allocate.
//
// Optional feature macro: DCACHE_LRU_EN
//    defined   : LRU replacement (per-set bit updated on hits and fills)
//    undefined : FIFO replacement (per-set bit toggles on each committed fill)
//
// Ports:
//    clk        in   1   clock, rising edge
//    rst        in   1   synchronous active-high reset (clears valid + LRU)
//    address    in  16   byte address: tag [15:4+SET_BITS], set [3+SET_BITS:4], word [3:1]
//    data_in    in  16   write-hit data or fill word
//    write      in   1   store request
//    load_data  in   1   fill strobe (victim way, word address[3:1])
//    load_tag   in   1   fill commit (victim tag + valid)
//    data_out   out 16   hitting word, 0 on miss
//    cache_miss out  1   no valid matching way in the set
module data_cache #(
   parameter int SET_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   input  logic [15:0] data_in,
   input  logic        write,
   input  logic        load_data,
   input  logic        load_tag,
   output logic [15:0] data_out,
   output logic        cache_miss
);

   localparam int NSETS = 1 << SET_BITS;
   localparam int TAG_W = 12 - SET_BITS;

   logic [15:0]      data_q  [2][NSETS][8];
   logic [TAG_W-1:0] tag_q   [2][NSETS];
   logic [NSETS-1:0] valid_q [2];
   logic [NSETS-1:0] valid_d [2];
   logic [NSETS-1:0] lru_q;
   logic [NSETS-1:0] lru_d;

   logic [TAG_W-1:0]    addr_tag;
   logic [SET_BITS-1:0] set_idx;
   logic [2:0]          word_idx;
   logic                hit0;
   logic                hit1;
   logic                victim;
   logic                data_we;
   logic                data_way;
   logic                tag_we;
   logic                unused_addr_bit;

   assign addr_tag        = address[15:4+SET_BITS];
   assign set_idx         = address[3+SET_BITS:4];
   assign word_idx        = address[3:1];
   assign unused_addr_bit = address[0];

   assign hit0       = valid_q[0][set_idx] && (tag_q[0][set_idx] == addr_tag);
   assign hit1       = valid_q[1][set_idx] && (tag_q[1][set_idx] == addr_tag);
   assign cache_miss = ~(hit0 | hit1);
   assign data_out   = hit0 ? data_q[0][set_idx][word_idx] :
                       hit1 ? data_q[1][set_idx][word_idx] : 16'h0000;

   // Victim depends only on valid/LRU state, which is untouched until load_tag,
   // so it stays the same way for every word of a fill.
   always_comb begin
      victim = lru_q[set_idx];
      if (!valid_q[0][set_idx]) begin
         victim = 1'b0;
      end else if (!valid_q[1][set_idx]) begin
         victim = 1'b1;
      end
   end

   always_comb begin
      valid_d  = valid_q;
      lru_d    = lru_q;
      data_we  = 1'b0;
      data_way = victim;
      tag_we   = 1'b0;
      if (load_data || load_tag) begin
         // Fill strobes only act on a miss: this is what prevents a duplicate
         // tag from ever being installed. Any concurrent write is dropped.
         if (load_data && cache_miss) begin
            data_we = 1'b1;
         end
         if (load_tag && cache_miss) begin
            tag_we                    = 1'b1;
            valid_d[victim][set_idx]  = 1'b1;
`ifdef DCACHE_LRU_EN
            lru_d[set_idx]            = ~victim;
`else
            lru_d[set_idx]            = ~lru_q[set_idx];
`endif
         end
      end else if (!cache_miss) begin
         if (write) begin
            data_we  = 1'b1;
            data_way = hit1;
         end
`ifdef DCACHE_LRU_EN
         lru_d[set_idx] = ~hit1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         lru_q      <= '0;
      end else begin
         valid_q <= valid_d;
         lru_q   <= lru_d;
      end
   end

   // Data and tag arrays are never reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if (!rst && data_we) begin
         data_q[data_way][set_idx][word_idx] <= data_in;
      end
      if (!rst && tag_we) begin
         tag_q[victim][set_idx] <= addr_tag;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - scoreboard testbench for data_cache
module tb_data_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] address;
   logic [15:0] data_in;
   logic        write;
   logic        load_data;
   logic        load_tag;
   logic [15:0] data_out;
   logic        cache_miss;

   always #5 clk = ~clk;

   data_cache #(.SET_BITS(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .address    (address),
      .data_in    (data_in),
      .write      (write),
      .load_data  (load_data),
      .load_tag   (load_tag),
      .data_out   (data_out),
      .cache_miss (cache_miss)
   );

   logic [16:0] exp_q[$];
   string       name_q[$];
   logic        chk_en = 1'b0;
   int          checks = 0;
   int          errors = 0;

   // Monitor: whenever the bench marks a cycle as observable, pop and compare.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [16:0] e;
         string       nm;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: got miss=%0b data=%h, required an expectation", cache_miss, data_out);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if ({cache_miss, data_out} !== e) begin
               errors++;
               $display("FAIL %s: got miss=%0b data=%h, required miss=%0b data=%h",
                        nm, cache_miss, data_out, e[16], e[15:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] d,
                        input logic wr, input logic ld, input logic lt, input logic r);
      address = a; data_in = d; write = wr; load_data = ld; load_tag = lt; rst = r;
      chk_en = 1'b0;
      tick();
   endtask

   // Apply inputs for one cycle and queue the expected lookup result.
   task automatic obs(input string nm, input logic [15:0] a, input logic [15:0] d,
                      input logic wr, input logic m, input logic [15:0] exp_d);
      address = a; data_in = d; write = wr; load_data = 1'b0; load_tag = 1'b0; rst = 1'b0;
      exp_q.push_back({m, exp_d});
      name_q.push_back(nm);
      chk_en = 1'b1;
      tick();
      chk_en = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [15:0] a, input logic m, input logic [15:0] exp_d);
      obs(nm, a, 16'h0000, 1'b0, m, exp_d);
   endtask

   task automatic fill(input logic [15:0] base, input logic [7:0][15:0] w, input int nwords, input logic commit);
      for (int i = 0; i < nwords; i++) begin
         drive(base + 16'(2 * i), w[i], 1'b0, 1'b1, commit && (i == nwords - 1), 1'b0);
      end
   endtask

   function automatic logic [7:0][15:0] seq(input logic [15:0] first);
      logic [7:0][15:0] r;
      for (int i = 0; i < 8; i++) r[i] = first + 16'(i);
      return r;
   endfunction

   logic [7:0][15:0] w_a;
   logic [7:0][15:0] w_b;

   initial begin
      address = '0; data_in = '0; write = 0; load_data = 0; load_tag = 0; rst = 1;
      w_a = {16'h00BD, 16'h00BC, 16'h00BB, 16'h00BA, 16'h00AD, 16'h00AC, 16'h00AB, 16'h00AA};
      w_b = {16'h00CD, 16'h00CC, 16'h00CB, 16'h00CA, 16'h00DD, 16'h00DC, 16'h00DB, 16'h00DA};
      tick();
      for (int i = 0; i < 3; i++) drive(16'h0000, 16'h0000, 0, 0, 0, 1'b1);

      // Post-reset miss
      rd("reset_miss", 16'h0000, 1'b1, 16'h0000);

      // Fill set 0 way 0 with tag 0 (LRU -> 1)
      fill(16'h0000, w_a, 8, 1'b1);
      rd("hit_0000", 16'h0000, 1'b0, 16'h00AA);
      rd("hit_0006", 16'h0006, 1'b0, 16'h00AD);
      rd("miss_0608", 16'h0608, 1'b1, 16'h0000);

      // Second way: tag 0x20 into way 1 (LRU -> 0, FIFO bit -> 0)
      fill(16'h8000, w_b, 8, 1'b1);
      rd("hit_8000", 16'h8000, 1'b0, 16'h00DA);
      rd("hit_0000_again", 16'h0000, 1'b0, 16'h00AA);
      rd("hit_800e", 16'h800E, 1'b0, 16'h00CD);
      rd("miss_0608_b", 16'h0608, 1'b1, 16'h0000);

      // Write hit, then write miss
      obs("write_hit_cycle", 16'h8006, 16'h00FF, 1'b1, 1'b0, 16'h00DD);
      rd("after_write_8006", 16'h8006, 1'b0, 16'h00FF);
      obs("write_miss_cycle", 16'h0608, 16'h1234, 1'b1, 1'b1, 16'h0000);
      rd("after_write_miss", 16'h0608, 1'b1, 16'h0000);
      rd("way0_intact", 16'h0006, 1'b0, 16'h00AD);

      // Touch 0x8000 last so way 0 is LRU; FIFO bit is 0 after two fills
      rd("touch_8000", 16'h8000, 1'b0, 16'h00DA);
      fill(16'h0400, seq(16'h0140), 8, 1'b1);
      rd("evicted_0000", 16'h0000, 1'b1, 16'h0000);
      rd("hit_0404", 16'h0404, 1'b0, 16'h0142);
      rd("kept_8000", 16'h8000, 1'b0, 16'h00DA);

      // Third tag into set 0: LRU names way 0 (0x0400), FIFO names way 1 (0x8000)
      fill(16'h0800, seq(16'h0200), 8, 1'b1);
      rd("hit_080e", 16'h080E, 1'b0, 16'h0207);
`ifdef DCACHE_LRU_EN
      rd("repl_0400", 16'h0400, 1'b1, 16'h0000);
      rd("repl_8000", 16'h8000, 1'b0, 16'h00DA);
`else
      rd("repl_0400", 16'h0400, 1'b0, 16'h0140);
      rd("repl_8000", 16'h8000, 1'b1, 16'h0000);
`endif

      // Partial fill is invalid before commit; reset mid-fill invalidates everything
      fill(16'h0C00, seq(16'h0300), 4, 1'b0);
      rd("partial_invalid", 16'h0C00, 1'b1, 16'h0000);
      fill(16'h0C08, seq(16'h0304), 0, 1'b0);
      drive(16'h0C08, 16'h0304, 0, 1'b1, 0, 1'b1);
      rd("rst_mid_fill", 16'h0C00, 1'b1, 16'h0000);
      rd("rst_clears_0800", 16'h0800, 1'b1, 16'h0000);
      rd("rst_clears_0404", 16'h0404, 1'b1, 16'h0000);

      // Duplicate-tag guard and load_data-on-hit guard
      fill(16'h0000, seq(16'h0300), 8, 1'b1);
      drive(16'h0000, 16'hBEEF, 0, 0, 1'b1, 1'b0);
      drive(16'h0002, 16'hBEEF, 1'b1, 1'b1, 0, 1'b0);
      fill(16'h8000, seq(16'h0310), 8, 1'b1);
      rd("no_dup_0002", 16'h0002, 1'b0, 16'h0301);
      rd("no_dup_8002", 16'h8002, 1'b0, 16'h0311);
      rd("refill_000e", 16'h000E, 1'b0, 16'h0307);

      drive(16'h0000, 16'h0000, 0, 0, 0, 0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
